wr_arbiter: RTL
===============

# wr_arbiter

Write-side arbiter for the asynchronous FIFO: shares the single FIFO write port (`winc`/`wdata`/`full`) in the `wclk` domain between `N_REQ` packet requesters. It uses round-robin arbitration and locks the grant for a whole packet, so packets from different requesters never interleave in the FIFO. A beat counter force-releases a requester that exceeds `MAX_BURST` beats without `req_last`. The block sits between the write-side producers and the FIFO write port.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 32, FIFO data width
- `MAX_BURST`, 16, maximum beats per grant before forced release (≥1)
- `wclk`  in  1  write-domain clock; single clock of the block
- `wrst`  in  1  reset, asynchronous assert, active-high
- `req_valid`  in  N_REQ  per-requester beat valid
- `req_last`  in  N_REQ  per-requester last beat of packet, qualified by valid
- `req_data`  in  N_REQ*DATA_WIDTH  flat bus; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  N_REQ  per-requester beat accept
- `full`  in  1  FIFO full, from the write-side controller
- `winc`  out  1  FIFO write enable
- `wdata`  out  DATA_WIDTH  FIFO write data
- `grant_id`  out  $clog2(N_REQ)  index of the current owner; valid while `busy`
- `busy`  out  1  a grant is held (state LOCK)
- `burst_err`  out  1  single-cycle pulse on forced release

## Operation
- States: IDLE, LOCK.
- Registered state: state, `grant_id`, round-robin pointer `rr_ptr`, beat counter `beat_cnt` of width $clog2(MAX_BURST+1), and `burst_err`.
- IDLE:
  - If any `req_valid` is high, register `grant_id` as the first valid index at or after `rr_ptr`, searching upward modulo `N_REQ`. Move to LOCK with `beat_cnt`=0.
  - Otherwise stay in IDLE.
  - `req_ready` is all zero in IDLE.
- LOCK:
  - `req_ready[grant_id]` = !`full`; every other `req_ready` is 0.
  - A beat fires when `req_valid[grant_id]` && `req_ready[grant_id]`.
  - On a fire: `winc`=1, `wdata`=slice `grant_id`, and `beat_cnt`+1.
  - Fire with `req_last`: go to IDLE, `rr_ptr` = (`grant_id`+1) mod `N_REQ`.
  - Fire without `req_last` that brings `beat_cnt` to `MAX_BURST`: go to IDLE, `rr_ptr` advances as above, and `burst_err` pulses in the next cycle.
  - `req_valid` deasserting mid-packet does not release the grant; the block waits.
- `winc` and `wdata` are combinational from the registered grant, `full`, and `req_*`. `winc` is never high while `full` is high.
- `wdata` is don't-care when `winc`=0 and is driven as 0.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0, `busy`=0, `burst_err`=0, `req_ready`=0, `winc`=0, `wdata`=0.
- Latency:
  - One arbitration cycle: a first `req_valid` seen in IDLE at cycle t gives `req_ready` earliest at t+1.
  - Beat to FIFO: 0 cycles (same cycle as the handshake).
  - Each packet costs one IDLE bubble cycle.
- Throughput inside LOCK: one beat per cycle while `full`=0.
- `full` rising stalls in the same cycle. No beat is lost; the requester holds its data per valid/ready rules.
- Requesters must hold `req_valid`/`req_data`/`req_last` stable until accepted.
- A single-beat packet (`req_last` on the first beat) gives LOCK for exactly one firing cycle.
- `MAX_BURST`=1 means every beat releases the grant; `burst_err` pulses for every beat without `req_last`.
- `req_last` on the `MAX_BURST`-th beat is a normal release: no `burst_err`.
- Asserting `wrst` mid-packet returns all outputs to their reset values immediately. The partial packet is abandoned in the FIFO; dropping it is upstream's responsibility.

## Structure
- Shared package `asyn_fifo_pkg`: state encodings (IDLE=1'b0, LOCK=1'b1) and the width helper for `grant_id`/`beat_cnt`.
- Sub-module `rr_picker`: purely combinational. Inputs are an `N_REQ` request vector and `rr_ptr`; outputs are winner index and `any`. It is instantiated once.
- The top level holds the FSM, counters, and the data mux.

## Test plan
- Reset: assert `wrst` asynchronously mid-cycle -> all outputs 0 at once; after release, state IDLE and `rr_ptr`=0.
- Round-robin with all four requesters valid and 2-beat packets -> grants in order 0,1,2,3,0. `wdata` carries each requester's tag (0xA0..0xA3), and each packet occupies 3 cycles (1 bubble + 2 beats).
- Packet lock: requester 1 sends 4 beats with `req_valid` gapped while requester 0 is valid -> the 4 beats appear contiguous in the FIFO and requester 0 is granted only after `req_last`.
- Backpressure: `full`=1 for 3 cycles in the middle of a packet -> `winc`=0 and `req_ready`=0 during those cycles; no beat is duplicated or dropped and the data order is preserved.
- Forced release: with `MAX_BURST`=16, requester 2 streams 20 beats without `req_last` -> release after beat 16, `burst_err` high for exactly 1 cycle, and the next grant goes to requester 3 if it is valid.
- Reset mid-packet at beat 2 of 5 -> `winc` drops in the same cycle; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/asyn_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO write-side blocks:
// arbiter state encodings and the index-width helper.
package asyn_fifo_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // Width of an index able to hold 0..n-1, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// searching upward modulo N_REQ.
module rr_picker
  import asyn_fifo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_cand;
  logic          w_hit;

  // Scan offsets 0..N_REQ-1 from the pointer; the first hit wins
  always_comb begin
    o_idx  = {IW{1'b0}};
    o_any  = 1'b0;
    w_cand = {IW{1'b0}};
    w_hit  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % N_REQ);
      w_hit  = !o_any && i_req[w_cand];
      o_idx  = w_hit ? w_cand : o_idx;
      o_any  = o_any | i_req[w_cand];
    end
  end

endmodule

// File: rtl/wr_arbiter.sv
// Write-side arbiter: round-robin grant of the single FIFO write port,
// locked for a whole packet, with forced release after MAX_BURST beats.
module wr_arbiter
  import asyn_fifo_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  localparam int IW = idx_width(N_REQ),
  localparam int BW = idx_width(MAX_BURST + 1)
) (
  input  logic                        wclk,
  input  logic                        wrst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        full,
  output logic                        winc,
  output logic [DATA_WIDTH-1:0]       wdata,
  output logic [IW-1:0]               grant_id,
  output logic                        busy,
  output logic                        burst_err
);

  logic [0:0]    r_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_rr_ptr;
  logic [BW-1:0] r_beat_cnt;
  logic          r_burst_err;

  logic [IW-1:0] w_pick;
  logic          w_any;
  logic          w_lock;
  logic          w_fire;
  logic          w_last;
  logic [BW-1:0] w_cnt_next;
  logic [IW-1:0] w_ptr_next;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick),
    .o_any (w_any)
  );

  assign w_lock     = (r_state == ST_LOCK);
  assign w_fire     = w_lock && req_valid[r_grant] && !full;
  assign w_last     = req_last[r_grant];
  assign w_cnt_next = r_beat_cnt + BW'(1);
  assign w_ptr_next = (r_grant == IW'(N_REQ - 1)) ? {IW{1'b0}} : r_grant + IW'(1);

  // Only the owner sees ready, and only while the FIFO has room
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    if (w_lock && !full) begin
      req_ready[r_grant] = 1'b1;
    end else begin
      req_ready = {N_REQ{1'b0}};
    end
  end

  assign winc      = w_fire;
  assign wdata     = w_fire ? req_data[r_grant*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
  assign grant_id  = r_grant;
  assign busy      = w_lock;
  assign burst_err = r_burst_err;

  // Grant FSM; burst_err is a one-cycle pulse following a forced release
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state     <= ST_IDLE;
      r_grant     <= {IW{1'b0}};
      r_rr_ptr    <= {IW{1'b0}};
      r_beat_cnt  <= {BW{1'b0}};
      r_burst_err <= 1'b0;
    end else begin
      r_burst_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_LOCK;
            r_grant    <= w_pick;
            r_beat_cnt <= {BW{1'b0}};
          end
        end
        ST_LOCK: begin
          if (w_fire) begin
            r_beat_cnt <= w_cnt_next;
            if (w_last) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= w_ptr_next;
            end else if (w_cnt_next == BW'(MAX_BURST)) begin
              r_state     <= ST_IDLE;
              r_rr_ptr    <= w_ptr_next;
              r_burst_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
